shiftreg_deserializer: RTL and testbench
========================================

# shiftreg_deserializer

Serial-in, parallel-out receiver: the far end of the team's parallel-load, shift-right serializer. It collects `WIDTH` serial bits qualified by `shift_en` into a shift register and transfers each completed word to a holding register. The holding register is offered downstream over a valid/ready handshake. A sticky `overrun` flag reports words lost because the holding register was still occupied.

## Interface
- `WIDTH`, default 4: bits per word, must be ≥ 2.
- `LSB_FIRST`, default 1.
  - 1: first received bit lands in `par_out[0]`, matching the shift-right serializer.
  - 0: first received bit lands in `par_out[WIDTH-1]`.
- `clk`  in  1  single clock, rising edge.
- `areset_n`  in  1  reset, asynchronous, active-low.
- `sync_clr`  in  1  synchronous clear of the in-progress word: bit count and shift register.
- `shift_en`  in  1  sample `ser_in` this cycle.
- `ser_in`  in  1  serial data bit.
- `out_ready`  in  1  downstream accepts `par_out` this cycle.
- `ovr_clr`  in  1  synchronous clear of `overrun`.
- `par_out`  out  `WIDTH`  holding-register word.
- `out_valid`  out  1  `par_out` holds an unaccepted word.
- `overrun`  out  1  sticky: a completed word was dropped.
- `bit_cnt`  out  `$clog2(WIDTH)`  bits collected in the current word.

## Operation
- Reset (`areset_n` = 0, asynchronous): all outputs are 0.
  - `par_out` = 0, `out_valid` = 0, `overrun` = 0, `bit_cnt` = 0.
  - Shift register = 0; FSM goes to `EMPTY`.
- Shift:
  - On `shift_en` with `sync_clr` = 0, `ser_in` enters the shift register and `bit_cnt` increments.
  - `LSB_FIRST` = 1: shift right, insert at the MSB. `LSB_FIRST` = 0: shift left, insert at the LSB.
- Word complete: a cycle with `shift_en` = 1 and `bit_cnt` = `WIDTH-1`.
  - The completed word includes that cycle's `ser_in`.
  - `bit_cnt` wraps to 0; the shift register keeps shifting with no gap bit.
- `sync_clr` has priority over `shift_en`: `bit_cnt` and the shift register go to 0 and no completion occurs. It does not touch `par_out`, `out_valid` or `overrun`.
- Output FSM, states `EMPTY` and `FULL`; `out_valid` = (state == `FULL`).
  - `EMPTY` + complete → load `par_out`, go to `FULL`.
  - `FULL` + `out_ready`, no complete → go to `EMPTY`; `par_out` holds its value.
  - `FULL` + `out_ready` + complete (simultaneous) → load the new word, stay `FULL`, no overrun.
  - `FULL` + no `out_ready` + complete → new word dropped, `par_out` unchanged, `overrun` set.
- `overrun`:
  - Cleared by `ovr_clr`.
  - If set and clear occur in the same cycle, set wins.
- `out_ready` while `EMPTY` is ignored.

## Timing
- All state is registered; there is no combinational input-to-output path.
- Latency: `out_valid` rises in the cycle after the completing `shift_en` cycle, with `par_out` already valid in that cycle.
- Handshake:
  - A transfer occurs on a rising edge where `out_valid` and `out_ready` are both 1.
  - `par_out` is stable while `out_valid` = 1 and not accepted.
- Maximum throughput: one word per `WIDTH` cycles with `shift_en` held high, without overrun, as long as `out_ready` is asserted at least once per word.
- `bit_cnt` updates on the same edge as the shift.
- Reset mid-word or mid-handshake: asynchronous reset discards everything immediately. After release, the first `shift_en` is treated as bit 0.

## Structure
- Package `shiftreg_pkg`:
  - `typedef enum logic {EMPTY, FULL} deser_state_t`.
  - Function `cnt_w(WIDTH)` returning `$clog2(WIDTH)`.
- Sub-module `deser_bit_counter`: modulo-`WIDTH` counter with `clr`/`en` inputs and a `wrap` pulse output.
  - `clr` has priority over `en`.
  - `wrap` = `en` && count == `WIDTH-1`.
- Top level holds the shift register, holding register, FSM and overrun flag.

## Test plan
- `WIDTH` = 4, `LSB_FIRST` = 1, `out_ready` = 1.
  - Send 1, 0, 1, 1 with `shift_en` held high.
  - Required: `par_out` = 4'b1101 with `out_valid` high for exactly 1 cycle, starting the cycle after the 4th bit.
- `LSB_FIRST` = 0, same bits → `par_out` = 4'b1011.
- `out_ready` = 0, send two back-to-back words, 4'h5 then 4'hA.
  - Required: `par_out` stays 4'h5, `overrun` = 1.
  - Then `ovr_clr` → `overrun` = 0.
- Simultaneous accept and complete.
  - Setup: holding register contains 4'h3; the last bit of 4'hC arrives in the same cycle as `out_ready`.
  - Required: `par_out` = 4'hC, `out_valid` stays 1, `overrun` = 0.
- `sync_clr` after 2 bits with `shift_en` also high, then 4 new bits of 4'h9.
  - Required: `bit_cnt` = 0 after the clear, then `par_out` = 4'h9.
- `areset_n` pulsed low mid-word with `out_valid` = 1.
  - Required: all outputs are 0 asynchronously.
  - The next 4 bits form a complete word.

Source files
------------

// File: rtl/shiftreg_deserializer_pkg.sv
// shiftreg_deserializer_pkg: shared types and sizing helper for the serial-in, parallel-out receiver.
package shiftreg_pkg;
  typedef enum logic {EMPTY, FULL} deser_state_t;
  function automatic int cnt_w(int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/shiftreg_deserializer_if.sv
// shiftreg_deserializer_if: serial-side controls plus the parallel valid/ready output of the receiver.
interface shiftreg_deserializer_if #(parameter int WIDTH = 4);
  import shiftreg_pkg::*;
  logic                    sync_clr;
  logic                    shift_en;
  logic                    ser_in;
  logic                    out_ready;
  logic                    ovr_clr;
  logic [WIDTH-1:0]        par_out;
  logic                    out_valid;
  logic                    overrun;
  logic [cnt_w(WIDTH)-1:0] bit_cnt;
  modport master (
    output sync_clr, shift_en, ser_in, out_ready, ovr_clr,
    input  par_out, out_valid, overrun, bit_cnt
  );
  modport slave (
    input  sync_clr, shift_en, ser_in, out_ready, ovr_clr,
    output par_out, out_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/shiftreg_deserializer_bit_counter.sv
// deser_bit_counter: modulo-WIDTH bit counter; wrap pulses on the enabled cycle that holds the last count.
module deser_bit_counter
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic                    clr,
  input  logic                    en,
  output logic [cnt_w(WIDTH)-1:0] count,
  output logic                    wrap
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  assign wrap = en && count == LAST;
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/shiftreg_deserializer.sv
// shiftreg_deserializer: collects WIDTH serial bits into a word and offers it over valid/ready,
// flagging a sticky overrun when a completed word finds the holding register still occupied.
module shiftreg_deserializer
  import shiftreg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1
) (
  input logic                  clk,
  input logic                  areset_n,
  shiftreg_deserializer_if.slave bus
);
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] nxt;
  logic             wrap;
  logic             complete;
  logic             drop;
  logic             load;
  deser_state_t     state;
  deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .clr      (bus.sync_clr),
    .en       (bus.shift_en),
    .count    (bus.bit_cnt),
    .wrap     (wrap)
  );
  // nxt already contains this cycle's bit, so a completing word is loaded straight from it
  assign nxt      = LSB_FIRST ? {bus.ser_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bus.ser_in};
  assign complete = wrap && !bus.sync_clr;
  assign drop     = complete && state == FULL && !bus.out_ready;
  assign load     = complete && !drop;
  assign bus.out_valid = state == FULL;
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      sr          <= '0;
      state       <= EMPTY;
      bus.par_out <= '0;
      bus.overrun <= 1'b0;
    end else begin
      sr          <= bus.sync_clr ? '0 : bus.shift_en ? nxt : sr;
      bus.overrun <= drop || (bus.overrun && !bus.ovr_clr);
      if (load) bus.par_out <= nxt;
      state <= load ? FULL : (state == FULL && bus.out_ready) ? EMPTY : state;
    end
endmodule

// File: tb/tb_shiftreg_deserializer.sv
// tb_shiftreg_deserializer: scoreboard bench driving an LSB-first and an MSB-first receiver in lockstep.
module tb_shiftreg_deserializer;
  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [3:0] q[$];
  shiftreg_deserializer_if #(.WIDTH(4)) a ();
  shiftreg_deserializer_if #(.WIDTH(4)) b ();
  assign b.sync_clr  = a.sync_clr;
  assign b.shift_en  = a.shift_en;
  assign b.ser_in    = a.ser_in;
  assign b.out_ready = a.out_ready;
  assign b.ovr_clr   = a.ovr_clr;
  shiftreg_deserializer #(.WIDTH(4), .LSB_FIRST(1)) dut_a (.clk(clk), .areset_n(areset_n), .bus(a));
  shiftreg_deserializer #(.WIDTH(4), .LSB_FIRST(0)) dut_b (.clk(clk), .areset_n(areset_n), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] rev(input logic [3:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[3-i];
    return r;
  endfunction
  task automatic drive(input logic sh, input logic bit_in, input logic rdy, input logic oclr, input logic sclr);
    a.shift_en  = sh;
    a.ser_in    = bit_in;
    a.out_ready = rdy;
    a.ovr_clr   = oclr;
    a.sync_clr  = sclr;
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [3:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) drive(1'b1, w[i], rdy, 1'b0, 1'b0);
  endtask
  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_par"}, a.par_out, 0);
    check({tag, "_valid"}, a.out_valid, 0);
    check({tag, "_ovr"}, a.overrun, 0);
    check({tag, "_cnt"}, a.bit_cnt, 0);
    check({tag, "_par_msb"}, b.par_out, 0);
  endtask
  // every transfer pops the oldest expected word; both receivers must agree on it
  always @(negedge clk) begin
    logic [3:0] exp;
    if (areset_n && a.out_valid && a.out_ready) begin
      exp = (q.size() > 0) ? q.pop_front() : ~a.par_out;
      check("sb_word", a.par_out, exp);
      check("sb_word_msb", b.par_out, rev(exp));
      check("sb_valid_msb", b.out_valid, 1);
    end
  end
  initial begin
    a.shift_en = 0; a.ser_in = 0; a.out_ready = 0; a.ovr_clr = 0; a.sync_clr = 0;
    #12;
    check_zero("reset");
    areset_n = 1'b1;
    // bits 1,0,1,1 -> 4'b1101 LSB-first, 4'b1011 MSB-first
    q.push_back(4'b1101);
    send_word(4'b1101, 1'b1);
    check("latency_valid", a.out_valid, 1);
    check("latency_par_msb", b.par_out, 4'b1011);
    idle(1'b1);
    check("one_cycle_valid", a.out_valid, 0);
    // back-to-back words with no acceptance: the second is dropped
    q.push_back(4'h5);
    send_word(4'h5, 1'b0);
    send_word(4'hA, 1'b0);
    check("ovr_par_kept", a.par_out, 4'h5);
    check("ovr_set", a.overrun, 1);
    check("ovr_valid", a.out_valid, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_cleared", a.overrun, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, i[0], 1'b0, 1'b1, 1'b0);
    check("ovr_set_wins", a.overrun, 1);
    check("ovr_set_wins_par", a.par_out, 4'h5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("drain_valid", a.out_valid, 0);
    check("drain_ovr", a.overrun, 0);
    // accept of 4'h3 coincides with completion of 4'hC
    q.push_back(4'h3);
    q.push_back(4'hC);
    send_word(4'h3, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, i == 2, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("simul_par", a.par_out, 4'hC);
    check("simul_valid", a.out_valid, 1);
    check("simul_ovr", a.overrun, 0);
    idle(1'b1);
    idle(1'b0);
    // sync_clr after two bits, with shift_en still asserted
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("cnt_two", a.bit_cnt, 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("sclr_cnt", a.bit_cnt, 0);
    check("sclr_no_valid", a.out_valid, 0);
    q.push_back(4'h9);
    send_word(4'h9, 1'b1);
    idle(1'b1);
    check("sclr_done_valid", a.out_valid, 0);
    // asynchronous reset with a word held and a partial word in flight
    send_word(4'h7, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", a.out_valid, 1);
    #2 areset_n = 1'b0;
    #1 check_zero("async_rst");
    #1 areset_n = 1'b1;
    q.push_back(4'hB);
    send_word(4'hB, 1'b1);
    check("post_rst_valid", a.out_valid, 1);
    idle(1'b1);
    idle(1'b0);
    check("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
